// File: rtl/serial_image_loader.sv
`timescale 1ns/1ps
// Frame receiver: parses SYNC, width, height, pixels, checksum from a byte stream
// and issues one frame-memory write per pixel, with coded abort and inter-byte timeout.
module serial_image_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  image_width,
  output logic [7:0]  image_height
);

  typedef enum logic [2:0] {IDLE, WIDTH, HEIGHT, PIXELS, CHECK} state_t;

  localparam logic [23:0] TIMEOUT_VAL = 24'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  logic        rx_ready_d;
  logic        accept;
  logic [15:0] remaining, remaining_n;
  logic [15:0] addr, addr_n;
  logic [15:0] area;
  logic [7:0]  sum, sum_n;
  logic [23:0] tcount, tcount_n;
  logic        mem_we_n, done_n, error_n;
  logic [15:0] mem_addr_n;
  logic [7:0]  mem_data_n, width_n, height_n;
  logic [1:0]  err_code_n;

  // Only the rising edge of rx_ready counts, so a held level yields one byte.
  assign accept = rx_ready & ~rx_ready_d;
  assign area   = {8'd0, image_width} * {8'd0, rx_data};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rx_ready_d   <= 1'b0;
      remaining    <= '0;
      addr         <= '0;
      sum          <= '0;
      tcount       <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
      image_width  <= '0;
      image_height <= '0;
    end else begin
      state        <= state_n;
      rx_ready_d   <= rx_ready;
      remaining    <= remaining_n;
      addr         <= addr_n;
      sum          <= sum_n;
      tcount       <= tcount_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_data     <= mem_data_n;
      done         <= done_n;
      error        <= error_n;
      err_code     <= err_code_n;
      image_width  <= width_n;
      image_height <= height_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    addr_n      = addr;
    sum_n       = sum;
    tcount_n    = (state == IDLE) ? 24'd0 : tcount + 24'd1;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_data_n  = mem_data;
    done_n      = 1'b0;
    error_n     = 1'b0;
    err_code_n  = err_code;
    width_n     = image_width;
    height_n    = image_height;

    // An accepted byte takes priority over a timeout on the same edge.
    if (accept) begin
      tcount_n = '0;
      unique case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_n = WIDTH;
        end
        WIDTH: begin
          width_n = rx_data;
          state_n = HEIGHT;
        end
        HEIGHT: begin
          height_n = rx_data;
          if (image_width == 8'd0 || rx_data == 8'd0) begin
            error_n    = 1'b1;
            err_code_n = 2'b10;
            state_n    = IDLE;
          end else begin
            remaining_n = area;
            addr_n      = '0;
            sum_n       = '0;
            state_n     = PIXELS;
          end
        end
        PIXELS: begin
          mem_we_n    = 1'b1;
          mem_addr_n  = addr;
          mem_data_n  = rx_data;
          addr_n      = addr + 16'd1;
          sum_n       = sum + rx_data;
          remaining_n = remaining - 16'd1;
          if (remaining == 16'd1) state_n = CHECK;
        end
        CHECK: begin
          if (rx_data == sum) begin
            done_n = 1'b1;
          end else begin
            error_n    = 1'b1;
            err_code_n = 2'b11;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcount == TIMEOUT_VAL) begin
      error_n    = 1'b1;
      err_code_n = 2'b01;
      state_n    = IDLE;
      tcount_n   = '0;
    end
  end

endmodule
